// File: rtl/product_accumulator.sv
// product_accumulator: clocked stage after the combinational multiplier.
// Sums TERMS consecutive products per frame behind a valid/ready input and
// holds each result until the consumer accepts it.
// Optional feature: define MAC_SATURATE_EN to clamp the sum at all-ones on
// overflow instead of wrapping modulo 2^ACC_W.
module product_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned TERMS = 8,
    parameter int unsigned ACC_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*N-1:0]     p_in,
    input  logic               p_valid,
    output logic               p_ready,
    input  logic               clr,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic               ovf,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(TERMS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TERMS - 1);
    localparam logic SingleTerm = (TERMS == 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e           state;
    logic [CntW-1:0]  cnt;

    logic             accept;
    logic             last;
    logic             carry;
    logic             ovf_next;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;

    // Input handshake: only IDLE/ACCUM take products, and clr blocks intake.
    always_comb begin
        p_ready = ((state == StIdle) || (state == StAccum)) && !clr;
        accept  = p_valid && p_ready;
    end

    // Adder with one extra bit; the first product of a frame adds onto zero.
    always_comb begin
        base  = (state == StIdle) ? '0 : acc_out;
        sum   = {1'b0, base} + (ACC_W + 1)'(p_in);
        carry = sum[ACC_W];
`ifdef MAC_SATURATE_EN
        // Once clamped, later adds carry again (or add zero) and stay at all-ones.
        acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        // Sticky flag restarts at the first product of each frame.
        ovf_next = ((state == StIdle) ? 1'b0 : ovf) | carry;
        last     = (state == StIdle) ? SingleTerm : (cnt == LastCnt);
    end

    // Frame FSM with registered result, valid, overflow and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            acc_out   <= '0;
            cnt       <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            // Abort wins over every handshake, including a pending result.
            state     <= StIdle;
            acc_out   <= '0;
            cnt       <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        acc_out <= acc_next;
                        cnt     <= CntW'(1);
                        ovf     <= ovf_next;
                        busy    <= 1'b1;
                        if (last) begin
                            state     <= StDone;
                            acc_valid <= 1'b1;
                        end else begin
                            state <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        acc_out <= acc_next;
                        cnt     <= cnt + CntW'(1);
                        ovf     <= ovf_next;
                        if (last) begin
                            state     <= StDone;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Result and ovf hold until the consumer takes them.
                    if (acc_ready) begin
                        state     <= StIdle;
                        acc_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    acc_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
